trigger_sequencer: RTL
======================

# trigger_sequencer

Controller that feeds the `trigger` input of the clock-and-trigger encoders (2-phase divide-by-2 encoder and 4-phase duty-cycle encoder). It accepts data words through a valid/ready FIFO and serializes them MSB-first onto `trigger`. Each bit is held for exactly one encoder frame: 2 `fastclk` cycles in mode 0, 4 in mode 1. It sits upstream of the encoder, in the same `fastclk` domain, and owns frame alignment so the encoder's frame-enabled synchronizer always samples a stable bit.

## Interface
Parameters:
- `WORD_W`, 8 — bits per word; ≥2.
- `FIFO_DEPTH`, 4 — word FIFO entries; power of two, ≥2.

Ports:
- `fastclk` in 1 — single clock, all logic on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `mode` in 1 — frame length select: 0 = 2 cycles, 1 = 4 cycles; applied only as described below.
- `in_data` in WORD_W — word to transmit.
- `in_valid` in 1 — `in_data` valid.
- `in_ready` out 1 — FIFO can accept a word.
- `flush` in 1 — synchronous abort: empties the FIFO and ends the current word.
- `trigger` out 1 — serialized bit to encoder; 0 = idle/normal clock.
- `frame_start` out 1 — high during the cycle where phase == 0.
- `word_done` out 1 — one-cycle pulse when a word's last bit frame completes.
- `busy` out 1 — state SHIFT or FIFO non-empty.

## Operation
- Reset values: `trigger`=0, `word_done`=0, `busy`=0, `in_ready`=1, `frame_start`=1 (phase=0), FIFO empty, state IDLE, `mode_q`=0.
- Phase counter `phase`: free-running in all states; increments every edge and wraps at FRAME-1 → 0 (FRAME = 2 if `mode_q`=0, else 4). The boundary edge is the edge where phase wraps to 0.
- `mode_q`: loaded from `mode` only on a boundary edge while IDLE with the FIFO empty and no push in that cycle. `mode` is ignored otherwise.
- FIFO:
  - `in_ready` = (count < FIFO_DEPTH) && !`flush`.
  - Push on `in_valid && in_ready`.
  - When full, `in_ready`=0 even if a pop occurs in the same cycle.
- State machine:
  - IDLE: on a boundary edge with the FIFO non-empty → pop, load the shift register, `trigger` ← word[WORD_W-1], bit counter ← WORD_W-1, go to SHIFT.
  - SHIFT, boundary edge, bit counter > 0: `trigger` ← next bit, decrement the bit counter.
  - SHIFT, boundary edge, bit counter == 0: pulse `word_done`. Then:
    - FIFO non-empty → pop and start the next word in the same edge (back-to-back, no gap frame).
    - FIFO empty → `trigger` ← 0, go to IDLE.
  - Non-boundary edges: `trigger` holds.
- `flush`=1 at an edge:
  - count ← 0, `trigger` ← 0, state ← IDLE; the push in that cycle is dropped.
  - `word_done` is not pulsed; phase is unaffected.
  - `flush` takes priority over pop and push.
- Simultaneous push and pop with a non-full FIFO: count unchanged, and the data order is preserved.
- `reset_n` asserted mid-word: all state returns to reset values immediately; the partial word is discarded.

## Timing
- `trigger` changes only on boundary edges (or on a flush or reset), so it is stable for the full FRAME cycles.
- Latency from a push into an empty FIFO while IDLE to the first bit on `trigger`: the next boundary edge after the push edge.
  - Mode 0: 1–2 cycles.
  - Mode 1: 1–4 cycles.
  - A push on the boundary edge itself waits for the following boundary.
- One word occupies `trigger` for WORD_W×FRAME cycles.
- `word_done` is high for the single cycle following the final boundary edge of the word.
- `busy` is combinational from state and count.

## Test plan
- Reset, mode 1: push 0xA5 while IDLE with phase=1.
  - `trigger` goes 1 at the next boundary, then 1,0,1,0,0,1,0,1, each held 4 cycles.
  - `word_done` pulses once, 32 cycles after the first bit.
  - `trigger` returns to 0; `busy` falls.
- Mode 0: push 0xFF, 0x00, 0x81 back-to-back.
  - 24 consecutive bit frames of 2 cycles each, with no idle frame between words.
  - 3 `word_done` pulses, 16 cycles apart.
- FIFO full: hold `in_valid`=1 with `mode_q`=1.
  - Words 1 (popped) and 2–5 are accepted; `in_ready` goes 0 with 4 entries.
  - `in_ready` rises for 1 cycle after each pop.
  - All accepted words appear in order.
- `flush` asserted during bit 3 of a word with 2 words queued.
  - Next edge: `trigger`=0, `busy`=0, no `word_done`.
  - The push presented in the flush cycle is not stored.
- Mode change: toggle `mode` 0→1 during SHIFT.
  - Frame length stays 2 until IDLE with the FIFO empty.
  - The next word then uses 4-cycle frames.
  - `frame_start` period changes exactly at that boundary.
- `reset_n` pulsed low mid-word.
  - `trigger`=0 and `in_ready`=1 immediately.
  - After release, the FIFO is empty and a new push transmits correctly.

Source files
------------

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: buffers words in a small FIFO and shifts them MSB-first
// onto `trigger`, holding each bit for one encoder frame (2 or 4 fastclk
// cycles) so the downstream encoder always samples a stable bit.
module trigger_sequencer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              fastclk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              trigger,
    output logic              frame_start,
    output logic              word_done,
    output logic              busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(WORD_W);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WORD_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_nxt;

    logic [1:0]        phase;
    logic              mode_q;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     bit_cnt;

    logic boundary;
    logic fifo_empty;
    logic push;
    logic pop;
    logic load;
    logic advance;
    logic finish;

    // The boundary edge is the one on which phase wraps back to zero.
    assign boundary    = mode_q ? (phase == 2'd3) : (phase == 2'd1);
    assign frame_start = (phase == 2'd0);
    assign fifo_empty  = (count == '0);
    // A full FIFO stays not-ready even if a pop frees a slot this cycle.
    assign in_ready    = (count < COUNT_FULL) && !flush;
    assign push        = in_valid && in_ready;
    assign busy        = (state == SHIFT) || !fifo_empty;

    // Free-running frame phase counter and frame-length latch.
    always_ff @(posedge fastclk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= 2'd0;
            mode_q <= 1'b0;
        end else begin
            phase <= boundary ? 2'd0 : phase + 2'd1;
            // Frame length may only change when nothing is queued or in flight.
            if (boundary && (state == IDLE) && fifo_empty && !push) begin
                mode_q <= mode;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge fastclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and shift control; every transition happens on a boundary edge.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else if (boundary) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        advance = 1'b1;
                    end else begin
                        finish = 1'b1;
                        // Chain straight into the next word without a gap frame.
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; flush clears everything and drops the push.
    always_ff @(posedge fastclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage and shift-register data (no reset needed on data).
    always_ff @(posedge fastclk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
        if (load) begin
            sreg <= mem[rd_ptr];
        end
    end

    // Serial output, bit counter and end-of-word pulse.
    always_ff @(posedge fastclk or negedge reset_n) begin
        if (!reset_n) begin
            trigger   <= 1'b0;
            word_done <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            word_done <= finish;
            if (flush) begin
                trigger <= 1'b0;
            end else if (load) begin
                trigger <= mem[rd_ptr][WORD_W-1];
                bit_cnt <= LAST_BIT;
            end else if (advance) begin
                trigger <= sreg[bit_cnt - 1'b1];
                bit_cnt <= bit_cnt - 1'b1;
            end else if (finish) begin
                trigger <= 1'b0;
            end
        end
    end

endmodule
